// File: rtl/serdes_tx_scheduler_if.sv
// serdes_tx_scheduler_if: requester and serializer-side bundle.
// master = traffic source/sink, slave = scheduler.
interface serdes_tx_scheduler_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]   i_req_valid;
  logic [NUM_REQ*8-1:0] i_req_data;
  logic [NUM_REQ-1:0]   i_req_last;
  logic [NUM_REQ-1:0]   o_req_ready;
  logic                 i_word_req;
  logic [7:0]           o_data;
  logic                 o_k;
  logic                 o_data_valid;
  logic [2:0]           o_grant_id;
  logic                 o_busy;

  modport master (
    output i_req_valid, i_req_data, i_req_last,
    output i_word_req,
    input  o_req_ready, o_data, o_k,
    input  o_data_valid, o_grant_id, o_busy
  );

  modport slave (
    input  i_req_valid, i_req_data, i_req_last,
    input  i_word_req,
    output o_req_ready, o_data, o_k,
    output o_data_valid, o_grant_id, o_busy
  );
endinterface

// File: rtl/serdes_tx_scheduler.sv
// serdes_tx_scheduler: round-robin packet scheduler feeding one 8b/10b lane.
// Ports: clk, i_rst_n (sync, active-low), bus (requesters + serializer words).
module serdes_tx_scheduler #(
  parameter int NUM_REQ      = 4,
  parameter int DATA_WIDTH   = 8,
  parameter int MAX_BURST    = 16,
  parameter int ALIGN_PERIOD = 256
) (
  input  logic                  clk,
  input  logic                  i_rst_n,
  serdes_tx_scheduler_if.slave  bus
);

  localparam int AW = $clog2(ALIGN_PERIOD);
  localparam logic [AW-1:0] ALIGN_MAX = AW'(ALIGN_PERIOD - 1);
  localparam logic [7:0] BURST_MAX = 8'(MAX_BURST);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HDR  = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;

  localparam logic [7:0] K_COMMA = 8'hBC;
  localparam logic [7:0] K_SOF   = 8'hFB;
  localparam logic [7:0] K_EOF   = 8'hFD;
  localparam logic [7:0] K_EOFC  = 8'hF7;
  localparam logic [7:0] K_STALL = 8'h1C;

  logic [1:0]    r_state;
  logic [2:0]    r_grant;
  logic [2:0]    r_last;
  logic [7:0]    r_burst;
  logic [AW-1:0] r_align;
  logic          r_term;
  logic          r_cont;
  logic [7:0]    r_data;
  logic          r_k;
  logic          r_dv;
  logic          r_busy;

  logic [NUM_REQ-1:0]    w_gsel;
  logic                  w_gvalid;
  logic                  w_glast;
  logic [DATA_WIDTH-1:0] w_gdata;
  logic                  w_hi_found;
  logic                  w_lo_found;
  logic [2:0]            w_hi;
  logic [2:0]            w_lo;
  logic [2:0]            w_pick;
  logic                  w_any;
  logic                  w_align_pend;
  logic [AW-1:0]         w_align_nx;
  logic [7:0]            w_burst_nx;
  logic                  w_take;

  always_comb begin
    w_gsel  = '0;
    w_gdata = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      w_gsel[j] = (r_grant == 3'(j));
      if (w_gsel[j])
        w_gdata = bus.i_req_data[j*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign w_gvalid = |(bus.i_req_valid & w_gsel);
  assign w_glast  = |(bus.i_req_last & w_gsel);

  // First valid above r_last wins; otherwise wrap to lowest valid.
  always_comb begin
    w_hi_found = 1'b0;
    w_lo_found = 1'b0;
    w_hi       = 3'd0;
    w_lo       = 3'd0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (bus.i_req_valid[j] && !w_hi_found && (3'(j) > r_last)) begin
        w_hi       = 3'(j);
        w_hi_found = 1'b1;
      end
      if (bus.i_req_valid[j] && !w_lo_found) begin
        w_lo       = 3'(j);
        w_lo_found = 1'b1;
      end
    end
    w_pick = w_hi_found ? w_hi : w_lo;
  end

  assign w_any        = |bus.i_req_valid;
  assign w_align_pend = (r_align == ALIGN_MAX);
  assign w_align_nx   = w_align_pend ? r_align : r_align + 1'b1;
  assign w_burst_nx   = r_burst + 8'd1;

  // A terminator slot never consumes a byte.
  assign w_take = bus.i_word_req && (r_state == S_DATA) &&
                  !r_term && w_gvalid;

  assign bus.o_req_ready  = w_take ? w_gsel : '0;
  assign bus.o_data       = r_data;
  assign bus.o_k          = r_k;
  assign bus.o_data_valid = r_dv;
  assign bus.o_grant_id   = r_grant;
  assign bus.o_busy       = r_busy;

  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_grant <= 3'd0;
      r_last  <= 3'(NUM_REQ - 1);
      r_burst <= 8'd0;
      r_align <= '0;
      r_term  <= 1'b0;
      r_cont  <= 1'b0;
      r_data  <= 8'h00;
      r_k     <= 1'b0;
      r_dv    <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_dv <= bus.i_word_req;
      if (bus.i_word_req) begin
        unique case (r_state)
          S_IDLE: begin
            if (w_align_pend || !w_any) begin
              r_data  <= K_COMMA;
              r_k     <= 1'b1;
              r_align <= '0;
            end else begin
              r_grant <= w_pick;
              r_last  <= w_pick;
              r_data  <= K_SOF;
              r_k     <= 1'b1;
              r_busy  <= 1'b1;
              r_burst <= 8'd0;
              r_align <= w_align_nx;
              r_state <= S_HDR;
            end
          end
          S_HDR: begin
            r_data  <= {5'b0, r_grant};
            r_k     <= 1'b0;
            r_align <= w_align_nx;
            r_state <= S_DATA;
          end
          S_DATA: begin
            r_align <= w_align_nx;
            if (r_term) begin
              r_data  <= r_cont ? K_EOFC : K_EOF;
              r_k     <= 1'b1;
              r_busy  <= 1'b0;
              r_term  <= 1'b0;
              r_state <= S_IDLE;
            end else if (w_gvalid) begin
              r_data  <= w_gdata;
              r_k     <= 1'b0;
              r_burst <= w_burst_nx;
              if (w_glast) begin
                r_term <= 1'b1;
                r_cont <= 1'b0;
              end else if (w_burst_nx == BURST_MAX) begin
                r_term <= 1'b1;
                r_cont <= 1'b1;
              end
            end else begin
              r_data <= K_STALL;
              r_k    <= 1'b1;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/serdes_tx_scheduler.md
Name: serdes_tx_scheduler

Overview:
- Byte-level transmit scheduler in front of the 8b/10b serializer.
- Shares one serial lane between NUM_REQ requesters using round-robin, packet-granular arbitration.
- Frames each grant with start/end K-codes, inserts stall fillers, and emits K28.5 idle/comma words.
- Supplies exactly one byte plus K flag per serializer word slot.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_WIDTH, 8, byte width (fixed 8; other values unsupported)
MAX_BURST, 16, max data bytes per grant before forced release (2..255)
ALIGN_PERIOD, 256, max words between K28.5 commas while not mid-packet (>=4)

Ports:
clk  in  1  clock
i_rst_n  in  1  synchronous reset, active-low
i_req_valid  in  NUM_REQ  requester i has a byte
i_req_data  in  NUM_REQ*8  requester i byte at [8i+7:8i]
i_req_last  in  NUM_REQ  byte is last of requester packet
o_req_ready  out  NUM_REQ  byte of requester i consumed this cycle (combinational)
i_word_req  in  1  1-cycle pulse: serializer wants next word
o_data  out  8  byte to serializer
o_k  out  1  o_data is a K-code
o_data_valid  out  1  1-cycle pulse, word valid
o_grant_id  out  3  current/last granted requester
o_busy  out  1  inside a packet (SOF emitted, EOF not yet emitted)

Behaviour:
- Interface decision: reset i_rst_n, synchronous, active-low; clock clk.
- Reset values: o_data=0x00, o_k=0, o_data_valid=0, o_req_ready=0, o_grant_id=0, o_busy=0. Internal last_grant=NUM_REQ-1, so requester 0 wins first. align_cnt=0, burst_cnt=0, state=IDLE.
- Reset asserted mid-packet aborts immediately; no EOF is emitted.
- Timing: every action is taken on a cycle with i_word_req=1. Outputs are registered, so o_data/o_k/o_data_valid appear on the next cycle.
- Exactly one o_data_valid pulse per i_word_req pulse; no output on other cycles.
- i_word_req arriving on the cycle o_data_valid is high is legal.
- K-codes: K28.5=0xBC idle/comma; K27.7=0xFB SOF; K29.7=0xFD EOF; K23.7=0xF7 EOF-continue; K28.0=0x1C stall.
- States: IDLE, HDR, DATA.
- IDLE, on word slot:
  - If align_pending, or no i_req_valid: emit K28.5, clear align_pending, align_cnt=0.
  - Otherwise: pick the first valid requester scanning last_grant+1 upward with wrap; set grant, o_grant_id, last_grant; emit SOF; set o_busy; burst_cnt=0; go to HDR.
- HDR, on word slot: emit data byte {5'b0, grant_id} with k=0; go to DATA.
- DATA, on word slot:
  - Grant valid=1: o_req_ready[grant]=1 in the same cycle; emit the byte with k=0; burst_cnt+1.
  - If last=1: EOF is sent in the next slot.
  - Else if burst_cnt reaches MAX_BURST: EOF-continue is sent in the next slot.
  - Grant valid=0: emit K28.0 stall; burst_cnt unchanged; stay in DATA.
- Terminator slot: emit EOF or EOF-continue; clear o_busy; return to IDLE.
  - The slot after a terminator is always arbitration or comma, never a direct SOF in the same slot.
- o_req_ready is never asserted for a non-granted requester, outside DATA, or without i_word_req.
- align_cnt increments on every emitted word except K28.5 and saturates at ALIGN_PERIOD-1.
- align_pending sets when align_cnt reaches ALIGN_PERIOD-1. It is honoured only in IDLE and never interrupts a packet.
- Pending align beats waiting requesters for one slot; arbitration resumes the following slot.
- A requester whose valid drops before grant loses nothing; round-robin pointer moves only on an actual grant.
- Simultaneous requests: strict round-robin, with no requester granted twice in a row while another is valid.

Test Plan:
- Idle lane: no requests, 5 word pulses → five words 0xBC with k=1; o_busy=0; o_req_ready=0.
- Single packet: req0 sends 0x11, 0x22 (last), 6 pulses → FB(k), 00, 11, 22, FD(k), BC(k); o_req_ready[0] pulses twice; o_busy high from SOF through EOF.
- Round-robin: req1 and req2 each hold valid with 1-byte packets (last) → FB,01,aa,FD then FB,02,bb,FD; next grant returns to 1.
- Burst limit: MAX_BURST=16, req3 streams 20 bytes with no last → 16 bytes then F7(k), then re-arbitration; remaining 4 bytes go in a second packet.
- Stall and align: req0 valid drops for 2 slots mid-packet → two 0x1C(k), burst_cnt unchanged. With ALIGN_PERIOD=8 and continuous traffic, a 0xBC(k) is inserted right after the EOF that follows the count reaching 7.
- Reset mid-packet: assert i_rst_n=0 for 1 cycle during DATA → all outputs reset, no EOF emitted; next grant goes to requester 0 after an SOF.
